instruction_sequencer: RTL and testbench

- Consumes 32-bit instructions assembled by the host-side instruction buffer and queues them in a small FIFO.
- Decodes each instruction and executes it against the text-mode framebuffer: cursor and colour registers, character writes, and a full-screen clear.
- Shares the framebuffer write port with video scanout through a request/grant handshake.
- Sits between the instruction buffer and the VRAM port arbiter.

---
 rtl/instruction_sequencer.sv | 172 +++++++++++++++++
 tb/tb_instruction_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Text-mode instruction sequencer: queues host instructions in a small FIFO, decodes them,
// and drives cursor/colour state and framebuffer writes through a request/grant port.
module instruction_sequencer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_instruction,
    input  logic              i_valid,
    output logic              o_full,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_bad_op,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [15:0]       o_fb_data,
    input  logic              i_fb_gnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CX_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CY_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [CX_W-1:0]   LAST_X    = CX_W'(COLS - 1);
    localparam logic [CY_W-1:0]   LAST_Y    = CY_W'(ROWS - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_X     = 8'h01;
    localparam logic [7:0] OP_SET_Y     = 8'h02;
    localparam logic [7:0] OP_PUT_CHAR  = 8'h03;
    localparam logic [7:0] OP_CLEAR     = 8'h04;
    localparam logic [7:0] OP_SET_COLOR = 8'h05;

    // Only opcode and arg0 are stored; the reserved upper half is ignored.
    logic [15:0]       fifo_mem [DEPTH];
    logic [15:0]       instr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic [1:0]        state_reg;
    logic              valid_d_reg;
    logic              overflow_reg, bad_op_reg, fb_we_reg;
    logic [ADDR_W-1:0] fb_addr_reg;
    logic [15:0]       fb_data_reg;
    logic [CX_W-1:0]   cursor_x_reg;
    logic [CY_W-1:0]   cursor_y_reg;
    logic [7:0]        colour_reg;

    logic              reserved_unused;
    logic              push_req, push, pop, full;
    logic [7:0]        opcode, arg0;
    logic [ADDR_W-1:0] cell_addr;

    assign reserved_unused = ^i_instruction[31:16];
    assign full      = (count_reg == FULL_CNT);
    assign pop       = (state_reg == ST_IDLE) && (count_reg != '0);
    assign push_req  = i_valid && !valid_d_reg;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign push      = push_req && (!full || pop);
    assign opcode    = instr_reg[7:0];
    assign arg0      = instr_reg[15:8];
    assign cell_addr = ADDR_W'(cursor_y_reg) * ADDR_W'(COLS) + ADDR_W'(cursor_x_reg);

    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= i_instruction[15:0];
        if (pop)  instr_reg <= fifo_mem[rd_ptr_reg];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            state_reg    <= ST_IDLE;
            valid_d_reg  <= 1'b0;
            overflow_reg <= 1'b0;
            bad_op_reg   <= 1'b0;
            fb_we_reg    <= 1'b0;
            fb_addr_reg  <= '0;
            fb_data_reg  <= 16'h0F00;
            cursor_x_reg <= '0;
            cursor_y_reg <= '0;
            colour_reg   <= 8'h0F;
        end else begin
            valid_d_reg  <= i_valid;
            overflow_reg <= push_req && full && !pop;
            bad_op_reg   <= 1'b0;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                ST_IDLE: begin
                    if (pop) state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_reg <= ST_IDLE;
                    case (opcode)
                        OP_NOP: state_reg <= ST_IDLE;
                        OP_SET_X: begin
                            if (32'(arg0) < COLS) cursor_x_reg <= CX_W'(arg0);
                            else                  cursor_x_reg <= LAST_X;
                        end
                        OP_SET_Y: begin
                            if (32'(arg0) < ROWS) cursor_y_reg <= CY_W'(arg0);
                            else                  cursor_y_reg <= LAST_Y;
                        end
                        OP_PUT_CHAR: begin
                            fb_addr_reg <= cell_addr;
                            fb_data_reg <= {colour_reg, arg0};
                            fb_we_reg   <= 1'b1;
                            state_reg   <= ST_WRITE;
                        end
                        OP_CLEAR: begin
                            fb_addr_reg <= '0;
                            fb_data_reg <= {colour_reg, arg0};
                            fb_we_reg   <= 1'b1;
                            state_reg   <= ST_CLEAR;
                        end
                        OP_SET_COLOR: colour_reg <= arg0;
                        default:      bad_op_reg <= 1'b1;
                    endcase
                end
                ST_WRITE: begin
                    if (i_fb_gnt) begin
                        fb_we_reg <= 1'b0;
                        state_reg <= ST_IDLE;
                        if (cursor_x_reg == LAST_X) begin
                            cursor_x_reg <= '0;
                            cursor_y_reg <= (cursor_y_reg == LAST_Y) ? '0 : cursor_y_reg + 1'b1;
                        end else begin
                            cursor_x_reg <= cursor_x_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    // Clear sweep: the address only advances on granted cycles.
                    if (i_fb_gnt) begin
                        if (fb_addr_reg == LAST_ADDR) begin
                            fb_we_reg    <= 1'b0;
                            state_reg    <= ST_IDLE;
                            cursor_x_reg <= '0;
                            cursor_y_reg <= '0;
                        end else begin
                            fb_addr_reg <= fb_addr_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_full     = full;
    assign o_busy     = (count_reg != '0) || (state_reg != ST_IDLE);
    assign o_overflow = overflow_reg;
    assign o_bad_op   = bad_op_reg;
    assign o_fb_we    = fb_we_reg;
    assign o_fb_addr  = fb_addr_reg;
    assign o_fb_data  = fb_data_reg;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized self-checking bench for instruction_sequencer against a screen-level model
// that tracks cursor position linearly and predicts every framebuffer write in order.
module tb_instruction_sequencer;
    localparam int COLS = 80, ROWS = 30, ADDR_W = 12, DEPTH = 4;
    localparam int CELLS = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       instruction = '0;
    logic              valid = 1'b0;
    logic              full, busy, overflow, bad_op, fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [15:0]       fb_data;
    logic              gnt = 1'b0;

    instruction_sequencer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst), .i_instruction(instruction), .i_valid(valid),
        .o_full(full), .o_busy(busy), .o_overflow(overflow), .o_bad_op(bad_op),
        .o_fb_we(fb_we), .o_fb_addr(fb_addr), .o_fb_data(fb_data), .i_fb_gnt(gnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0, tests_failed = 0;
    int mx = 0, my = 0, mc = 8'h0F;
    int exp_q[$];
    int bad_exp = 0, bad_seen = 0, ovf_seen = 0, wr_count = 0;
    int gnt_mode = 0;
    int last_addr = 0, last_data = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Screen-level model: cursor is a linear cell index, writes are predicted as {addr, data}.
    function automatic void model_apply(input int op, input int arg);
        int lin;
        case (op)
            0: ;
            1: mx = (arg < COLS) ? arg : COLS - 1;
            2: my = (arg < ROWS) ? arg : ROWS - 1;
            3: begin
                lin = my * COLS + mx;
                exp_q.push_back((lin << 16) | (mc << 8) | arg);
                lin = (lin + 1) % CELLS;
                mx = lin % COLS;
                my = lin / COLS;
            end
            4: begin
                for (int a = 0; a < CELLS; a++) exp_q.push_back((a << 16) | (mc << 8) | arg);
                mx = 0;
                my = 0;
            end
            5: mc = arg;
            default: bad_exp++;
        endcase
    endfunction

    function automatic void model_reset();
        mx = 0;
        my = 0;
        mc = 8'h0F;
        exp_q.delete();
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (gnt_mode)
                0:       gnt = 1'b1;
                1:       gnt = ~gnt;
                2:       gnt = 1'($urandom_range(0, 1));
                default: gnt = 1'b0;
            endcase
        end
    end

    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bad_op)   bad_seen++;
                if (overflow) ovf_seen++;
                if (fb_we && gnt) begin
                    wr_count++;
                    last_addr = int'(fb_addr);
                    last_data = int'(fb_data);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {4'b0, fb_addr, fb_data}, 32'(e));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input int arg, input bit wait_space, input bit accepted);
        if (wait_space) begin
            for (int c = 0; c < 2000 && full; c++) tick();
            check("fifo_space", full, 1'b0);
        end
        instruction = {16'($urandom()), 8'(arg), 8'(op)};
        valid = 1'b1;
        $display("[TB] send op=%02h arg=%02h", op, arg);
        if (accepted) model_apply(op, arg);
        tick();
        valid = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int limit);
        for (int c = 0; c < limit && (busy || exp_q.size() != 0); c++) tick();
        check("idle_busy", busy, 1'b0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        check("bad_op_count", 32'(bad_seen), 32'(bad_exp));
    endtask

    initial begin
        int lat, wr_base, ovf_base, r, op;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_we", fb_we, 1'b0);
        check("rst_addr", 32'(fb_addr), 32'd0);
        check("rst_data", fb_data, 16'h0F00);
        check("rst_full", full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_bad", bad_op, 1'b0);
        tick();

        // Basic placement with grant tied high.
        gnt_mode = 0;
        send(1, 5, 1, 1);
        send(2, 2, 1, 1);
        send(3, 8'h41, 1, 1);
        wait_idle(200);
        check("t1_addr", 32'(last_addr), 32'd165);
        check("t1_data", 32'(last_data), 32'h0F41);
        send(3, 8'h20, 1, 1);
        wait_idle(200);
        check("t1_cursor_after", 32'(last_addr), 32'd166);

        // Corner cell and wrap, then clamp on SET_X.
        send(1, 79, 1, 1);
        send(2, 29, 1, 1);
        send(3, 8'h42, 1, 1);
        wait_idle(200);
        check("corner_addr", 32'(last_addr), 32'd2399);
        send(3, 8'h43, 1, 1);
        wait_idle(200);
        check("wrap_addr", 32'(last_addr), 32'd0);
        send(1, 200, 1, 1);
        send(3, 8'h44, 1, 1);
        wait_idle(200);
        check("clamp_x_addr", 32'(last_addr), 32'd79);

        // Latency from empty and idle: o_fb_we first high three cycles after the edge cycle.
        instruction = {16'h0, 8'h45, 8'h03};
        valid = 1'b1;
        $display("[TB] send op=03 arg=45 (latency)");
        model_apply(3, 8'h45);
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (fb_we && lat < 0) lat = k;
        end
        tick();
        valid = 1'b0;
        tick();
        check("write_latency", 32'(lat), 32'd3);
        wait_idle(200);

        // Full-screen clear with grant toggling.
        gnt_mode = 1;
        send(5, 8'h1E, 1, 1);
        wr_base = wr_count;
        send(4, 8'h20, 1, 1);
        wait_idle(20000);
        check("clear_count", 32'(wr_count - wr_base), 32'(CELLS));
        check("clear_last_addr", 32'(last_addr), 32'd2399);
        check("clear_last_data", 32'(last_data), 32'h1E20);

        // Five edges while a clear is stalled: four queued, one dropped.
        gnt_mode = 3;
        send(4, 8'h00, 1, 1);
        for (int c = 0; c < 20 && !fb_we; c++) tick();
        check("clear_started", fb_we, 1'b1);
        ovf_base = ovf_seen;
        send(1, 3, 0, 1);
        send(2, 4, 0, 1);
        send(3, 8'h61, 0, 1);
        send(5, 8'h2A, 0, 1);
        check("fifo_full", full, 1'b1);
        send(3, 8'h62, 0, 0);
        check("overflow_pulses", 32'(ovf_seen - ovf_base), 32'd1);
        gnt_mode = 1;
        wait_idle(20000);
        check("overflow_pulses_end", 32'(ovf_seen - ovf_base), 32'd1);
        check("queued_put_addr", 32'(last_addr), 32'd323);
        check("queued_put_data", 32'(last_data), 32'h1E61);

        // Level held high captures once; unknown opcode changes nothing.
        gnt_mode = 0;
        wr_base = wr_count;
        instruction = {16'h0, 8'h63, 8'h03};
        valid = 1'b1;
        $display("[TB] send op=03 arg=63 (held high)");
        model_apply(3, 8'h63);
        repeat (10) tick();
        valid = 1'b0;
        tick();
        wait_idle(200);
        check("held_writes", 32'(wr_count - wr_base), 32'd1);
        send(8'h7F, 8'h11, 1, 1);
        send(3, 8'h64, 1, 1);
        wait_idle(200);
        check("after_bad_data", 32'(last_data), 32'h2A64);

        // Randomized instruction stream with random grant.
        gnt_mode = 2;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       op = 0;
                1, 2:    op = 1;
                3, 9:    op = 2;
                4, 5, 6: op = 3;
                7:       op = 5;
                default: op = $urandom_range(6, 255);
            endcase
            send(op, $urandom_range(0, 255), 1, 1);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle(5000);

        // Reset in the middle of a clear discards everything queued.
        gnt_mode = 1;
        send(4, 8'h2E, 1, 1);
        send(1, 7, 1, 1);
        send(3, 8'h55, 1, 1);
        for (int c = 0; c < 2000 && !(fb_we && fb_addr == 12'd100); c++) tick();
        check("reached_addr_100", 32'(fb_addr), 32'd100);
        gnt_mode = 3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_mid_we", fb_we, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_full", full, 1'b0);
        check("rst_mid_data", fb_data, 16'h0F00);
        gnt_mode = 0;
        wr_base = wr_count;
        repeat (10) tick();
        check("rst_no_writes", 32'(wr_count - wr_base), 32'd0);
        send(3, 8'h5A, 1, 1);
        wait_idle(200);
        check("rst_cursor_addr", 32'(last_addr), 32'd0);
        check("rst_colour_data", 32'(last_data), 32'h0F5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
